interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Clocked interrupt scheduler for the 8259 PIC. Latches IR0-IR7 into IRR and
//  resolves priority against the mask and ISR, using fixed or rotating priority
//  with fully nested mode. Asserts INT, runs the two-pulse INTA handshake and
//  returns the vector byte. Applies OCW2 EOI/rotate commands and AEOI.
//  Sits between the control-word decode logic (supplies mask, vector base,
//  AEOI, OCW2) and the data bus buffer.
// PARAMETERS
//  NUM_IR        8    number of request lines; fixed at 8, 3-bit level encoding
//  SPURIOUS_LVL  7    level returned when INTA arrives with no eligible request
// PORTS
//  clk           in   1  system clock; all state updates on rising edge
//  rst           in   1  asynchronous, active-high reset
//  ir            in   8  request lines, synchronous to clk, rising-edge triggered
//  maskreg       in   8  OCW1 mask; 1 = level masked
//  vector_base   in   5  ICW2[7:3]; upper bits of vector
//  AEOI          in   1  auto-EOI enable (ICW4[1])
//  ocw2_valid    in   1  one-cycle strobe: OCW2 written this cycle
//  R_SL_EOI      in   3  OCW2[7:5] command
//  ocw2_level    in   3  OCW2[2:0] target level
//  INTA          in   1  active-low acknowledge, synchronous to clk
//  INT           out  1  interrupt request to CPU, registered
//  vector_out    out  8  {vector_base, level}; valid while vector_valid=1
//  vector_valid  out  1  high while second INTA pulse is low
//  irr           out  8  interrupt request register
//  isr           out  8  in-service register
// BEHAVIOUR
//  Reset: irr=0, isr=0, INT=0, vector_out=0, vector_valid=0, state=IDLE,
//   lowest-priority pointer lp=7 (IR0 highest). ir_q=0, inta_q=1. Reset
//   mid-handshake aborts to IDLE, and no ISR bit is set.
//  IRR: ir_q<=ir each cycle. irr[i] sets on ir[i]&~ir_q[i] and clears at ACK1
//   for the granted level. Set wins over clear only for a different level.
//   Masked requests stay latched in irr.
//  Priority: order is lp+1, lp+2 ... lp (mod 8). Eligible = irr&~maskreg.
//   Winner = first eligible level strictly higher in priority than the
//   highest isr bit (fully nested). An equal or lower level waits.
//  INT <= (winner exists) && state==IDLE. Latency: ir rises before edge k ->
//   irr set after k -> INT high after k+1.
//  FSM (INTA edges from inta_q): IDLE -fall-> ACK1 -rise-> WAIT2 -fall->
//   ACK2 -rise-> IDLE.
//   On entering ACK1: freeze winner as lvl; isr[lvl]<=1; irr[lvl]<=0; INT<=0.
//    If no winner: lvl=SPURIOUS_LVL and isr/irr are unchanged.
//   ACK2: vector_out={vector_base,lvl}; vector_valid=1 until the INTA rise.
//   On ACK2 exit with AEOI=1: isr[lvl]<=0. If rotate-in-AEOI is set: lp<=lvl.
//   A falling INTA in ACK1 or ACK2 is ignored (no state change).
//  OCW2 (ocw2_valid), R_SL_EOI:
//   001 non-specific EOI: clear highest-priority isr bit.
//   011 specific EOI: clear isr[ocw2_level].
//   101 rotate on non-specific EOI: clear highest isr bit h; lp<=h.
//   111 rotate on specific EOI: clear isr[ocw2_level]; lp<=ocw2_level.
//   110 set priority: lp<=ocw2_level.
//   100 set / 000 clear rotate-in-AEOI flag. 010: no-op.
//   Any EOI with isr=0: no effect.
//  Simultaneous events: isr_next=(isr&~eoi_clr)|ack_set, where both terms are
//   computed from pre-edge values. The winner is computed from pre-edge
//   isr/lp. If an OCW2 rotate and an AEOI rotate land in the same cycle, the
//   OCW2 rotate wins.
// STRUCTURE
//  pic_pkg: R_SL_EOI encodings (EOI_NS, EOI_SP, ROT_NS, ROT_SP, SET_PRI,
//   ROT_AEOI_SET, ROT_AEOI_CLR), FSM state enum, NUM_IR.
//  Sub-module priority_resolver (combinational): inputs req[7:0], lp[2:0];
//   outputs found, level[2:0]. Two instances: one for the IRR winner, one for
//   the highest isr bit.
// TESTING
//  1 Reset, base=5'b01000, ir[3] rises, INTA pulse x2 -> INT high 2 cycles
//    after the rise; vector 8'h43; isr=8'h08; irr=0.
//  2 ir[5] then ir[2] pending, fixed priority -> IR2 served first
//    (vector ..010); after EOI 001 -> isr=0, INT reasserts for IR5.
//  3 isr[1] set, ir[4] rises -> INT stays 0 until EOI 011 lvl=1; then INT=1.
//  4 OCW2 110 lvl=3, then ir[0] and ir[4] pending -> IR4 granted first.
//  5 AEOI=1, ir[6] served -> isr[6] clears on second INTA rise; no EOI needed.
//  6 INTA with maskreg=8'hFF and ir[2] pending -> vector {base,3'b111}; isr
//    unchanged; irr[2] still 1. Reset during WAIT2 -> all outputs at reset
//    values.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared encodings and helpers for the 8259 interrupt sequencer
package pic_pkg;

  localparam int NUM_IR = 8;

  // OCW2 R/SL/EOI command field
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] EOI_NS       = 3'b001;
  localparam logic [2:0] EOI_SP       = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_NS       = 3'b101;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] ROT_SP       = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } pic_state_t;

  // Position of a level in the current rotation; 0 is the highest priority.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// rtl/priority_resolver.sv - finds the first set request scanning from lp+1 around to lp
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] lp,
  output logic       found,
  output logic [2:0] level
);

  always_comb begin
    found = 1'b0;
    level = 3'd0;
    // i = NUM_IR wraps back to lp itself, which is the lowest priority
    for (int i = 1; i <= NUM_IR; i++) begin
      if (!found && req[lp + 3'(i)]) begin
        found = 1'b1;
        level = lp + 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 8259 IRR/ISR scheduling, INTA handshake and OCW2 handling
module interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int SPURIOUS_LVL = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic [7:0] maskreg,
  input  logic [4:0] vector_base,
  input  logic       AEOI,
  input  logic       ocw2_valid,
  input  logic [2:0] R_SL_EOI,
  input  logic [2:0] ocw2_level,
  input  logic       INTA,
  output logic       INT,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  logic [7:0] ir_q;
  logic       inta_q;
  pic_state_t state;
  logic [2:0] lp;
  logic [2:0] lvl;
  logic       spurious;
  logic       rot_aeoi;

  logic       inta_fall;
  logic       inta_rise;
  logic [7:0] eligible;
  logic       elig_found;
  logic [2:0] elig_lvl;
  logic       isr_found;
  logic [2:0] isr_top;
  logic       win;
  logic [7:0] ack_set;
  logic       aeoi_done;
  logic [7:0] eoi_clr;
  logic       ocw_lp_we;
  logic [2:0] ocw_lp_val;

  assign inta_fall = inta_q & ~INTA;
  assign inta_rise = ~inta_q & INTA;
  assign eligible  = irr & ~maskreg;

  priority_resolver u_irr_res (
    .req   (eligible),
    .lp    (lp),
    .found (elig_found),
    .level (elig_lvl)
  );

  priority_resolver u_isr_res (
    .req   (isr),
    .lp    (lp),
    .found (isr_found),
    .level (isr_top)
  );

  // Fully nested: a request must strictly outrank everything in service
  assign win = elig_found &&
               (!isr_found || (prio_rank(elig_lvl, lp) < prio_rank(isr_top, lp)));

  assign ack_set   = ((state == ST_IDLE) && inta_fall && win) ? (8'b1 << elig_lvl) : 8'b0;
  assign aeoi_done = (state == ST_ACK2) && inta_rise && AEOI && !spurious;

  always_comb begin
    eoi_clr    = 8'b0;
    ocw_lp_we  = 1'b0;
    ocw_lp_val = ocw2_level;
    if (ocw2_valid) begin
      case (R_SL_EOI)
        EOI_NS: begin
          if (isr_found) eoi_clr[isr_top] = 1'b1;
        end
        EOI_SP: begin
          eoi_clr[ocw2_level] = 1'b1;
        end
        ROT_NS: begin
          if (isr_found) begin
            eoi_clr[isr_top] = 1'b1;
            ocw_lp_we        = 1'b1;
            ocw_lp_val       = isr_top;
          end
        end
        ROT_SP: begin
          if (isr_found) begin
            eoi_clr[ocw2_level] = 1'b1;
            ocw_lp_we           = 1'b1;
          end
        end
        SET_PRI: begin
          ocw_lp_we = 1'b1;
        end
        default: ;
      endcase
    end
    if (aeoi_done) eoi_clr[lvl] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q     <= 8'b0;
      inta_q   <= 1'b1;
      irr      <= 8'b0;
      isr      <= 8'b0;
      INT      <= 1'b0;
      lp       <= 3'd7;
      rot_aeoi <= 1'b0;
    end else begin
      ir_q   <= ir;
      inta_q <= INTA;
      // A new edge on the level being acknowledged is consumed by the ack
      irr    <= (irr | (ir & ~ir_q)) & ~ack_set;
      isr    <= (isr & ~eoi_clr) | ack_set;
      INT    <= win && (state == ST_IDLE) && !inta_fall;
      if (ocw_lp_we)
        lp <= ocw_lp_val;
      else if (aeoi_done && rot_aeoi)
        lp <= lvl;
      if (ocw2_valid && (R_SL_EOI == ROT_AEOI_SET))
        rot_aeoi <= 1'b1;
      else if (ocw2_valid && (R_SL_EOI == ROT_AEOI_CLR))
        rot_aeoi <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lvl          <= 3'd0;
      spurious     <= 1'b0;
      vector_out   <= 8'b0;
      vector_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inta_fall) begin
            state    <= ST_ACK1;
            lvl      <= win ? elig_lvl : 3'(SPURIOUS_LVL);
            spurious <= !win;
          end
        end
        ST_ACK1: begin
          if (inta_rise) state <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (inta_fall) begin
            state        <= ST_ACK2;
            vector_out   <= {vector_base, lvl};
            vector_valid <= 1'b1;
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state        <= ST_IDLE;
            vector_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - vector table, directed corners and randomized model check
module tb_interrupt_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ir = 8'h00;
  logic [7:0] maskreg = 8'h00;
  logic [4:0] vector_base = 5'b01000;
  logic       AEOI = 1'b0;
  logic       ocw2_valid = 1'b0;
  logic [2:0] R_SL_EOI = 3'd0;
  logic [2:0] ocw2_level = 3'd0;
  logic       INTA = 1'b1;
  logic       INT;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;

  interrupt_sequencer #(.SPURIOUS_LVL(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .ir           (ir),
    .maskreg      (maskreg),
    .vector_base  (vector_base),
    .AEOI         (AEOI),
    .ocw2_valid   (ocw2_valid),
    .R_SL_EOI     (R_SL_EOI),
    .ocw2_level   (ocw2_level),
    .INTA         (INTA),
    .INT          (INT),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .irr          (irr),
    .isr          (isr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sets of pending / in-service levels plus rotation pointer
  bit [7:0] m_irr;
  bit [7:0] m_isr;
  int       m_lp;
  bit       m_rot;

  function automatic int rnk(input int l);
    return (l - m_lp + 15) % 8;
  endfunction

  function automatic int m_top();
    int b = -1;
    for (int l = 0; l < 8; l++)
      if (m_isr[l] && (b < 0 || rnk(l) < rnk(b))) b = l;
    return b;
  endfunction

  function automatic int m_winner(input bit [7:0] mask);
    int t = m_top();
    int lim = (t < 0) ? 8 : rnk(t);
    int b = -1;
    for (int l = 0; l < 8; l++)
      if (m_irr[l] && !mask[l] && rnk(l) < lim && (b < 0 || rnk(l) < rnk(b))) b = l;
    return b;
  endfunction

  task automatic m_ack(input bit [7:0] mask, input bit aeoi, output int lvl, output bit [7:0] mid);
    int w = m_winner(mask);
    if (w >= 0) begin
      m_isr[w] = 1'b1;
      m_irr[w] = 1'b0;
      lvl = w;
      mid = m_isr;
      if (aeoi) begin
        m_isr[w] = 1'b0;
        if (m_rot) m_lp = w;
      end
    end else begin
      lvl = 7;
      mid = m_isr;
    end
  endtask

  task automatic m_ocw2(input logic [2:0] cmd, input int lv);
    int h = m_top();
    case (cmd)
      EOI_NS:       if (h >= 0) m_isr[h] = 1'b0;
      EOI_SP:       m_isr[lv] = 1'b0;
      ROT_NS:       if (h >= 0) begin m_isr[h] = 1'b0; m_lp = h; end
      ROT_SP:       if (m_isr != 0) begin m_isr[lv] = 1'b0; m_lp = lv; end
      SET_PRI:      m_lp = lv;
      ROT_AEOI_SET: m_rot = 1'b1;
      ROT_AEOI_CLR: m_rot = 1'b0;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ir = 8'h00; INTA = 1'b1; ocw2_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_irr = 0; m_isr = 0; m_lp = 7; m_rot = 0;
  endtask

  task automatic pulse_ir(input logic [7:0] bits);
    @(negedge clk); ir = bits;
    @(negedge clk); ir = 8'h00;
    @(negedge clk);
    m_irr |= bits;
  endtask

  task automatic ack(output logic [7:0] vec, output logic vv, output logic [7:0] mid, output logic vv_after);
    @(negedge clk); INTA = 1'b0;
    @(negedge clk); INTA = 1'b1;
    @(negedge clk); INTA = 1'b0;
    @(negedge clk); vec = vector_out; vv = vector_valid; mid = isr; INTA = 1'b1;
    @(negedge clk); vv_after = vector_valid;
  endtask

  task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lv);
    @(negedge clk); ocw2_valid = 1'b1; R_SL_EOI = cmd; ocw2_level = lv;
    @(negedge clk); ocw2_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] ir;
    logic [7:0] mask;
    logic       exp_int;
    logic [2:0] exp_lvl;
    logic [7:0] exp_isr;
    logic [7:0] exp_irr;
  } vec_t;

  vec_t tbl [6];

  logic [7:0] v, mid;
  logic       vv, vva;
  int         lvl;
  bit [7:0]   m_mid;

  initial begin
    tbl[0] = '{8'h08, 8'h00, 1'b1, 3'd3, 8'h08, 8'h00};
    tbl[1] = '{8'h24, 8'h00, 1'b1, 3'd2, 8'h04, 8'h20};
    tbl[2] = '{8'h81, 8'h01, 1'b1, 3'd7, 8'h80, 8'h01};
    tbl[3] = '{8'hFF, 8'hFE, 1'b1, 3'd0, 8'h01, 8'hFE};
    tbl[4] = '{8'h04, 8'h04, 1'b0, 3'd7, 8'h00, 8'h04};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 3'd7, 8'h00, 8'h00};

    do_reset();
    chk("reset_irr", irr, 8'h00);
    chk("reset_isr", isr, 8'h00);
    chk("reset_int", INT, 1'b0);
    chk("reset_vec", vector_out, 8'h00);
    chk("reset_vv", vector_valid, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      maskreg = tbl[i].mask; AEOI = 1'b0; vector_base = 5'b01000;
      pulse_ir(tbl[i].ir);
      chk($sformatf("tbl%0d_int", i), INT, tbl[i].exp_int);
      ack(v, vv, mid, vva);
      chk($sformatf("tbl%0d_vec", i), v, {5'b01000, tbl[i].exp_lvl});
      chk($sformatf("tbl%0d_vv", i), vv, 1'b1);
      chk($sformatf("tbl%0d_vv_drop", i), vva, 1'b0);
      chk($sformatf("tbl%0d_isr", i), isr, tbl[i].exp_isr);
      chk($sformatf("tbl%0d_irr", i), irr, tbl[i].exp_irr);
    end
    maskreg = 8'h00;

    // INT latency: rise before edge k, irr after k, INT after k+1
    do_reset();
    @(negedge clk); ir = 8'h08;
    @(negedge clk);
    chk("lat_irr", irr, 8'h08);
    chk("lat_int_early", INT, 1'b0);
    ir = 8'h00;
    @(negedge clk);
    chk("lat_int", INT, 1'b1);
    ack(v, vv, mid, vva);
    chk("t1_vec", v, 8'h43);
    chk("t1_isr", isr, 8'h08);

    // IR5 then IR2: IR2 first, then EOI hands over to IR5
    do_reset();
    pulse_ir(8'h20);
    pulse_ir(8'h04);
    ack(v, vv, mid, vva);
    chk("t2_vec_first", v, 8'h42);
    ocw2(EOI_NS, 3'd0);
    chk("t2_isr_eoi", isr, 8'h00);
    chk("t2_int_again", INT, 1'b1);
    ack(v, vv, mid, vva);
    chk("t2_vec_second", v, 8'h45);

    // Fully nested blocking until specific EOI
    do_reset();
    pulse_ir(8'h02);
    ack(v, vv, mid, vva);
    chk("t3_isr", isr, 8'h02);
    pulse_ir(8'h10);
    chk("t3_int_blocked", INT, 1'b0);
    ocw2(EOI_SP, 3'd1);
    chk("t3_isr_clr", isr, 8'h00);
    chk("t3_int_open", INT, 1'b1);

    // Set priority: lp=3 makes IR4 highest
    do_reset();
    ocw2(SET_PRI, 3'd3);
    pulse_ir(8'h11);
    ack(v, vv, mid, vva);
    chk("t4_vec", v, 8'h44);

    // AEOI clears isr at the second INTA rise; rotate-in-AEOI moves lp
    do_reset();
    AEOI = 1'b1;
    pulse_ir(8'h40);
    ack(v, vv, mid, vva);
    chk("t5_vec", v, 8'h46);
    chk("t5_isr_mid", mid, 8'h40);
    chk("t5_isr_after", isr, 8'h00);
    ocw2(ROT_AEOI_SET, 3'd0);
    pulse_ir(8'h40);
    ack(v, vv, mid, vva);
    pulse_ir(8'h81);
    ack(v, vv, mid, vva);
    chk("t5_rot_vec", v, 8'h47);
    ocw2(ROT_AEOI_CLR, 3'd0);
    AEOI = 1'b0;

    // Spurious ack, then asynchronous reset while waiting for the second pulse
    do_reset();
    maskreg = 8'hFF;
    pulse_ir(8'h04);
    chk("t6_int_masked", INT, 1'b0);
    ack(v, vv, mid, vva);
    chk("t6_vec", v, 8'h47);
    chk("t6_isr", isr, 8'h00);
    chk("t6_irr", irr, 8'h04);
    maskreg = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("t6_int_unmasked", INT, 1'b1);
    @(negedge clk); INTA = 1'b0;
    @(negedge clk); INTA = 1'b1;
    @(negedge clk);
    chk("t6_isr_wait2", isr, 8'h04);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_irr", irr, 8'h00);
    chk("t6_rst_isr", isr, 8'h00);
    chk("t6_rst_int", INT, 1'b0);
    chk("t6_rst_vv", vector_valid, 1'b0);
    chk("t6_rst_vec", vector_out, 8'h00);
    @(negedge clk); rst = 1'b0;
    m_irr = 0; m_isr = 0; m_lp = 7; m_rot = 0;
    ack(v, vv, mid, vva);
    chk("t6_post_vec", v, 8'h47);
    chk("t6_post_isr", isr, 8'h00);

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 60; it++) begin
      logic [7:0] bits, msk;
      logic [2:0] cmd, lv;
      bit         a;
      msk  = 8'($urandom) & 8'($urandom);
      bits = 8'($urandom) & 8'($urandom);
      a    = ($urandom_range(0, 3) == 0);
      maskreg = msk; AEOI = a; vector_base = 5'($urandom_range(0, 31));
      pulse_ir(bits);
      chk($sformatf("rnd%0d_irr", it), irr, m_irr);
      chk($sformatf("rnd%0d_int", it), INT, m_winner(msk) >= 0);
      ack(v, vv, mid, vva);
      m_ack(msk, a, lvl, m_mid);
      chk($sformatf("rnd%0d_vec", it), v, {vector_base, 3'(lvl)});
      chk($sformatf("rnd%0d_isr_mid", it), mid, m_mid);
      chk($sformatf("rnd%0d_isr", it), isr, m_isr);
      chk($sformatf("rnd%0d_irr_ack", it), irr, m_irr);
      cmd = 3'($urandom_range(0, 7));
      lv  = 3'($urandom_range(0, 7));
      ocw2(cmd, lv);
      m_ocw2(cmd, int'(lv));
      chk($sformatf("rnd%0d_isr_ocw", it), isr, m_isr);
      chk($sformatf("rnd%0d_int_ocw", it), INT, m_winner(msk) >= 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
